// File: rtl/scr1_tcm_arb_pkg.sv
// Shared types for the TCM data-port arbiter: memory interface enums plus
// the arbiter FSM state and master identifiers.
package scr1_tcm_arb_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic [1:0] {
        SCR1_TCM_ARB_IDLE = 2'b00,
        SCR1_TCM_ARB_BUSY = 2'b01,
        SCR1_TCM_ARB_ERR  = 2'b10
    } type_scr1_tcm_arb_state_e;

    typedef enum logic {
        SCR1_TCM_ARB_M0 = 1'b0,
        SCR1_TCM_ARB_M1 = 1'b1
    } type_scr1_tcm_arb_mst_e;

endpackage

// File: rtl/scr1_tcm_arb_sel.sv
// Combinational 2-way winner select: a lone requester always wins; on a tie
// the mode picks round-robin (opposite of last winner) or m0 unless forced.
module scr1_tcm_arb_sel
    import scr1_tcm_arb_pkg::*;
(
    input  logic                   i_arb_mode,
    input  logic                   i_m0_req,
    input  logic                   i_m1_req,
    input  type_scr1_tcm_arb_mst_e i_rr_last,
    input  logic                   i_force_m1,
    output logic                   o_vld,
    output type_scr1_tcm_arb_mst_e o_win
);

    always_comb begin
        o_vld = i_m0_req | i_m1_req;
        o_win = SCR1_TCM_ARB_M0;
        if (i_m0_req & i_m1_req) begin
            if (i_arb_mode) begin
                o_win = i_force_m1 ? SCR1_TCM_ARB_M1 : SCR1_TCM_ARB_M0;
            end else begin
                o_win = (i_rr_last == SCR1_TCM_ARB_M0) ? SCR1_TCM_ARB_M1 : SCR1_TCM_ARB_M0;
            end
        end else if (i_m1_req) begin
            o_win = SCR1_TCM_ARB_M1;
        end
    end

endmodule

// File: rtl/scr1_tcm_dmem_arb.sv
// Two-master arbiter on the TCM data port (m0 = core dmem, m1 = DMA/debug):
// one grant per cycle, one outstanding slave transaction, local m1 range errors.
module scr1_tcm_dmem_arb
    import scr1_tcm_arb_pkg::*;
#(
    parameter logic [31:0] TCM_SIZE    = 32'h0001_0000,
    parameter int          ARB_MODE    = 0,
    parameter int          M1_MAX_WAIT = 8
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m0_req,
    input  type_scr1_mem_cmd_e   m0_cmd,
    input  type_scr1_mem_width_e m0_width,
    input  logic [31:0]          m0_addr,
    input  logic [31:0]          m0_wdata,
    output logic                 m0_req_ack,
    output logic [31:0]          m0_rdata,
    output type_scr1_mem_resp_e  m0_resp,
    input  logic                 m1_req,
    input  type_scr1_mem_cmd_e   m1_cmd,
    input  type_scr1_mem_width_e m1_width,
    input  logic [31:0]          m1_addr,
    input  logic [31:0]          m1_wdata,
    output logic                 m1_req_ack,
    output logic [31:0]          m1_rdata,
    output type_scr1_mem_resp_e  m1_resp,
    output logic                 s_req,
    output type_scr1_mem_cmd_e   s_cmd,
    output type_scr1_mem_width_e s_width,
    output logic [31:0]          s_addr,
    output logic [31:0]          s_wdata,
    input  logic                 s_req_ack,
    input  logic [31:0]          s_rdata,
    input  type_scr1_mem_resp_e  s_resp
);

    localparam int WCW = $clog2(M1_MAX_WAIT + 1);

    type_scr1_tcm_arb_state_e r_state;
    type_scr1_tcm_arb_state_e w_state_nx;
    type_scr1_tcm_arb_mst_e   r_owner;
    type_scr1_tcm_arb_mst_e   r_rr_last;
    logic [WCW-1:0]           r_wait_cnt;

    type_scr1_tcm_arb_mst_e   w_sel_win;
    logic                     w_sel_vld;
    logic                     w_force_m1;
    logic                     w_s_rsp;
    logic                     w_m1_oor;
    logic                     w_arb_en;
    logic                     w_grant;
    logic                     w_win_m1;
    logic                     w_lerr;
    logic                     w_accept;

    assign w_force_m1 = (r_wait_cnt == WCW'(M1_MAX_WAIT));
    assign w_s_rsp    = (s_resp != SCR1_MEM_RESP_NOTRDY);
    assign w_m1_oor   = (m1_addr >= TCM_SIZE);

    scr1_tcm_arb_sel u_sel (
        .i_arb_mode (ARB_MODE != 0),
        .i_m0_req   (m0_req),
        .i_m1_req   (m1_req),
        .i_rr_last  (r_rr_last),
        .i_force_m1 (w_force_m1),
        .o_vld      (w_sel_vld),
        .o_win      (w_sel_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= SCR1_TCM_ARB_IDLE;
        else        r_state <= w_state_nx;
    end

    // Arbitration also runs in the cycle the slave responds, so a new
    // transaction can be issued back-to-back behind the completing one.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            SCR1_TCM_ARB_IDLE: w_arb_en = 1'b1;
            SCR1_TCM_ARB_BUSY: w_arb_en = w_s_rsp;
            default:           w_arb_en = 1'b0;
        endcase
        w_grant    = w_arb_en & w_sel_vld;
        w_win_m1   = (w_sel_win == SCR1_TCM_ARB_M1);
        w_lerr     = w_grant & w_win_m1 & w_m1_oor;
        s_req      = w_grant & ~w_lerr;
        w_accept   = s_req & s_req_ack;
        m0_req_ack = w_accept & ~w_win_m1;
        m1_req_ack = (w_accept & w_win_m1) | w_lerr;
        if (w_lerr)                                     w_state_nx = SCR1_TCM_ARB_ERR;
        else if (w_accept)                              w_state_nx = SCR1_TCM_ARB_BUSY;
        else if (r_state == SCR1_TCM_ARB_ERR)           w_state_nx = SCR1_TCM_ARB_IDLE;
        else if ((r_state == SCR1_TCM_ARB_BUSY) & w_s_rsp) w_state_nx = SCR1_TCM_ARB_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= SCR1_TCM_ARB_M0;
            r_rr_last  <= SCR1_TCM_ARB_M1;
            r_wait_cnt <= '0;
        end else begin
            if (w_accept) r_owner <= w_sel_win;
            if (m0_req_ack | m1_req_ack) begin
                r_rr_last <= m1_req_ack ? SCR1_TCM_ARB_M1 : SCR1_TCM_ARB_M0;
            end
            if (!m1_req | m1_req_ack) r_wait_cnt <= '0;
            else if (!w_force_m1)     r_wait_cnt <= r_wait_cnt + WCW'(1);
        end
    end

    always_comb begin
        s_cmd   = SCR1_MEM_CMD_RD;
        s_width = SCR1_MEM_WIDTH_BYTE;
        s_addr  = '0;
        s_wdata = '0;
        if (s_req) begin
            s_cmd   = w_win_m1 ? m1_cmd   : m0_cmd;
            s_width = w_win_m1 ? m1_width : m0_width;
            s_addr  = w_win_m1 ? m1_addr  : m0_addr;
            s_wdata = w_win_m1 ? m1_wdata : m0_wdata;
        end
    end

    // Only the registered owner sees the slave; a local error answers m1 directly.
    always_comb begin
        m0_resp  = SCR1_MEM_RESP_NOTRDY;
        m0_rdata = '0;
        m1_resp  = SCR1_MEM_RESP_NOTRDY;
        m1_rdata = '0;
        if (r_state == SCR1_TCM_ARB_BUSY) begin
            if (r_owner == SCR1_TCM_ARB_M1) begin
                m1_resp  = s_resp;
                m1_rdata = s_rdata;
            end else begin
                m0_resp  = s_resp;
                m0_rdata = s_rdata;
            end
        end else if (r_state == SCR1_TCM_ARB_ERR) begin
            m1_resp = SCR1_MEM_RESP_RDY_ER;
        end
    end

endmodule
